// File: rtl/hilbert_pkg.sv
// Shared defaults, width derivations and FSM state type for the Hilbert tap reader.
// HILBERT_PAIR_EN selects pair mode (antisymmetric tap folding) for the derived widths.
package hilbert_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAPS   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic int idx_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic int out_w(input int data_w);
`ifdef HILBERT_PAIR_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    function automatic int ntap(input int taps);
`ifdef HILBERT_PAIR_EN
        return taps / 2;
`else
        return taps;
`endif
    endfunction

endpackage

// File: rtl/hilbert_tap_reader_sample_ring.sv
// Circular sample buffer: one write port, read ports addressed by age k (0 = newest).
// The second read port exists only when HILBERT_PAIR_EN is defined.
module sample_ring
    import hilbert_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int TAPS   = DEF_TAPS,
    localparam int IDX_W  = idx_w(TAPS)
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     i_wr_en,
    input  logic signed [DATA_W-1:0] i_wr_data,
`ifdef HILBERT_PAIR_EN
    input  logic        [IDX_W-1:0]  i_rd_k1,
    output logic signed [DATA_W-1:0] o_rd_d1,
`endif
    input  logic        [IDX_W-1:0]  i_rd_k0,
    output logic signed [DATA_W-1:0] o_rd_d0
);

    logic signed [DATA_W-1:0] r_buf [TAPS];
    logic        [IDX_W-1:0]  r_wp;

    // Physical slot of the sample k writes older than the most recent one (at r_wp-1).
    function automatic logic [IDX_W-1:0] phys(input logic [IDX_W-1:0] wp,
                                              input logic [IDX_W-1:0] k);
        logic [IDX_W:0] newest;
        logic [IDX_W:0] kk;
        logic [IDX_W:0] t;
        newest = (wp == '0) ? (IDX_W+1)'(TAPS-1) : {1'b0, wp} - 1'b1;
        kk     = {1'b0, k};
        t      = (newest >= kk) ? newest - kk : newest + (IDX_W+1)'(TAPS) - kk;
        return IDX_W'(t);
    endfunction

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
            r_wp <= '0;
        end else if (i_wr_en) begin
            r_buf[r_wp] <= i_wr_data;
            r_wp        <= (r_wp == IDX_W'(TAPS-1)) ? '0 : r_wp + 1'b1;
        end
    end

    assign o_rd_d0 = r_buf[phys(r_wp, i_rd_k0)];
`ifdef HILBERT_PAIR_EN
    assign o_rd_d1 = r_buf[phys(r_wp, i_rd_k1)];
`endif

endmodule

// File: rtl/hilbert_tap_reader.sv
// Accepts one sample, then streams the delay-line window newest-first to the MAC.
// HILBERT_PAIR_EN folds antisymmetric tap pairs: TAPS/2 taps of x[n-k]-x[n-(TAPS-1-k)].
module hilbert_tap_reader
    import hilbert_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int TAPS   = DEF_TAPS,
    localparam int IDX_W  = idx_w(TAPS),
    localparam int OUT_W  = out_w(DATA_W)
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  tap_data,
    output logic        [IDX_W-1:0]  tap_idx,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic                     tap_last,
    output logic                     busy
);

    localparam int                NTAP   = ntap(TAPS);
    localparam logic [IDX_W-1:0]  LAST_K = IDX_W'(NTAP-1);

    state_t                   r_state, w_state_nxt;
    logic        [IDX_W-1:0]  r_k;
    logic                     r_in_ready, r_tap_valid, r_busy, r_tap_last;
    logic signed [OUT_W-1:0]  r_tap_data;

    logic                     w_accept, w_xfer, w_last_xfer;
    logic        [IDX_W-1:0]  w_k_nxt;
    logic signed [DATA_W-1:0] w_rd_d0, w_x0;
    logic signed [OUT_W-1:0]  w_tap_nxt;

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_xfer      = (r_state == READ) && tap_ready;
    assign w_last_xfer = w_xfer && (r_k == LAST_K);
    assign w_k_nxt     = w_accept ? '0 : r_k + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = READ;
            READ:    if (w_last_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // On the accept edge the new sample is not yet in the ring, so tap 0 bypasses it;
    // the ring still reads relative to the previous newest sample at that moment.
    assign w_x0 = w_accept ? in_data : w_rd_d0;

`ifdef HILBERT_PAIR_EN
    logic        [IDX_W-1:0]  w_rd_k1;
    logic signed [DATA_W-1:0] w_rd_d1;
    assign w_rd_k1   = w_accept ? IDX_W'(TAPS-2) : IDX_W'(TAPS-1) - w_k_nxt;
    assign w_tap_nxt = {w_x0[DATA_W-1], w_x0} - {w_rd_d1[DATA_W-1], w_rd_d1};
`else
    assign w_tap_nxt = w_x0;
`endif

    sample_ring #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_ring (
        .clk       (clk),
        .RST       (RST),
        .i_wr_en   (w_accept),
        .i_wr_data (in_data),
`ifdef HILBERT_PAIR_EN
        .i_rd_k1   (w_rd_k1),
        .o_rd_d1   (w_rd_d1),
`endif
        .i_rd_k0   (w_k_nxt),
        .o_rd_d0   (w_rd_d0)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_tap_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_tap_last  <= 1'b0;
            r_tap_data  <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_tap_valid <= (w_state_nxt == READ);
            r_busy      <= (w_state_nxt == READ);
            if (w_accept || (w_xfer && !w_last_xfer)) begin
                r_k        <= w_k_nxt;
                r_tap_data <= w_tap_nxt;
                r_tap_last <= (w_k_nxt == LAST_K);
            end else if (w_last_xfer) begin
                r_tap_last <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign tap_valid = r_tap_valid;
    assign busy      = r_busy;
    assign tap_last  = r_tap_last;
    assign tap_data  = r_tap_data;
    assign tap_idx   = r_k;

endmodule

// File: tb/tb_hilbert_tap_reader.sv
// Randomized self-checking bench for hilbert_tap_reader (TAPS=4, DATA_W=16).
// Define HILBERT_PAIR_EN for both bench and RTL to exercise pair mode.
module tb_hilbert_tap_reader;

    localparam int DATA_W = 16;
    localparam int TAPS   = 4;
    localparam int IDX_W  = 2;
`ifdef HILBERT_PAIR_EN
    localparam int OUT_W  = DATA_W + 1;
    localparam int NTAP   = TAPS / 2;
`else
    localparam int OUT_W  = DATA_W;
    localparam int NTAP   = TAPS;
`endif

    logic                     clk = 1'b0;
    logic                     RST;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  tap_data;
    logic        [IDX_W-1:0]  tap_idx;
    logic                     tap_valid;
    logic                     tap_ready;
    logic                     tap_last;
    logic                     busy;

    always #5 clk = ~clk;

    hilbert_tap_reader #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tap_data  (tap_data),
        .tap_idx   (tap_idx),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_last  (tap_last),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: sample history, hist[j] = x[n-j], zero before written.
    int hist [TAPS];

    // Observed transfers of one sequence.
    int cd [TAPS];
    int ci [TAPS];
    int cl [TAPS];
    int cc [TAPS];
    int ncol;

    function automatic int expect_tap(input int k);
`ifdef HILBERT_PAIR_EN
        return hist[k] - hist[TAPS-1-k];
`else
        return hist[k];
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
    endtask

    task automatic model_push(input int s);
        for (int i = TAPS-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b0;
        model_clear();
        @(negedge clk);
        RST = 1'b1;
    endtask

    // Offer one sample and wait (bounded) for it to be accepted.
    task automatic push(input int s);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL push_timeout in_ready got=0 want=1 sample=%0d", s);
        end else begin
            in_valid = 1'b1;
            in_data  = DATA_W'(s);
            @(posedge clk);
            model_push(s);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Record transfers of one sequence; rnd randomizes tap_ready and garbage in_valid.
    task automatic collect(input bit rnd);
        bit done;
        done = 1'b0;
        ncol = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            tap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = DATA_W'($urandom);
            if (tap_valid && tap_ready) begin
                cd[ncol] = int'(tap_data);
                ci[ncol] = int'(tap_idx);
                cl[ncol] = int'(tap_last);
                cc[ncol] = cyc;
                ncol++;
                if (tap_last || ncol == NTAP) begin
                    done     = 1'b1;
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        tap_ready = 1'b1;
    endtask

    task automatic test_reset();
        RST       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'sh1234;
        tap_ready = 1'b0;
        repeat (3) @(negedge clk);
        total += 6;
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        if (tap_valid !== 1'b0) begin bad++; $display("FAIL rst_tap_valid got=%b want=0", tap_valid); end
        if (tap_data !== '0)    begin bad++; $display("FAIL rst_tap_data got=%0d want=0", tap_data); end
        if (tap_idx !== '0)     begin bad++; $display("FAIL rst_tap_idx got=%0d want=0", tap_idx); end
        if (tap_last !== 1'b0)  begin bad++; $display("FAIL rst_tap_last got=%b want=0", tap_last); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        in_valid = 1'b0;
        model_clear();
        RST = 1'b1;
    endtask

    task automatic test_single_push();
        push(1);
        collect(1'b0);
        total++;
        if (ncol !== NTAP) begin bad++; $display("FAIL single_count got=%0d want=%0d", ncol, NTAP); end
        for (int k = 0; k < ncol; k++) begin
            total += 4;
            if (cd[k] !== expect_tap(k)) begin bad++; $display("FAIL single_data k=%0d got=%0d want=%0d", k, cd[k], expect_tap(k)); end
            if (ci[k] !== k)             begin bad++; $display("FAIL single_idx got=%0d want=%0d", ci[k], k); end
            if (cl[k] !== int'(k == NTAP-1)) begin bad++; $display("FAIL single_last k=%0d got=%0d want=%0d", k, cl[k], int'(k == NTAP-1)); end
            if (cc[k] !== k)             begin bad++; $display("FAIL single_latency k=%0d cycle got=%0d want=%0d", k, cc[k], k); end
        end
        @(negedge clk);
        total += 3;
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL single_in_ready_after got=%b want=1", in_ready); end
        if (tap_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got=%b want=0", tap_valid); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 1; s <= 5; s++) begin
            push(s);
            collect(1'b0);
        end
        total++;
        if (ncol !== NTAP) begin bad++; $display("FAIL wrap_count got=%0d want=%0d", ncol, NTAP); end
        for (int k = 0; k < ncol; k++) begin
            total++;
            if (cd[k] !== expect_tap(k)) begin bad++; $display("FAIL wrap_data k=%0d got=%0d want=%0d", k, cd[k], expect_tap(k)); end
        end
`ifndef HILBERT_PAIR_EN
        total++;
        if (cd[0] !== 5 || cd[1] !== 4 || cd[2] !== 3 || cd[3] !== 2) begin
            bad++;
            $display("FAIL wrap_seq got=%0d,%0d,%0d,%0d want=5,4,3,2", cd[0], cd[1], cd[2], cd[3]);
        end
`endif
    endtask

    task automatic test_backpressure();
        int d1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(int'($urandom_range(0, 65535)) - 32768);
            if (i < 3) collect(1'b0);
        end
        @(negedge clk);
        tap_ready = 1'b1;
        @(negedge clk);
        tap_ready = 1'b0;
        d1 = int'(tap_data);
        total += 2;
        if (tap_idx !== 2'd1)   begin bad++; $display("FAIL bp_idx_enter got=%0d want=1", tap_idx); end
        if (d1 !== expect_tap(1)) begin bad++; $display("FAIL bp_data_enter got=%0d want=%0d", d1, expect_tap(1)); end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total += 4;
            if (tap_valid !== 1'b1)        begin bad++; $display("FAIL bp_valid s=%0d got=%b want=1", s, tap_valid); end
            if (tap_idx !== 2'd1)          begin bad++; $display("FAIL bp_idx s=%0d got=%0d want=1", s, tap_idx); end
            if (int'(tap_data) !== d1)     begin bad++; $display("FAIL bp_data s=%0d got=%0d want=%0d", s, tap_data, d1); end
            if (tap_last !== (NTAP == 2))  begin bad++; $display("FAIL bp_last s=%0d got=%b want=%0d", s, tap_last, int'(NTAP == 2)); end
        end
        tap_ready = 1'b1;
        for (int k = 2; k < NTAP; k++) begin
            @(negedge clk);
            total += 2;
            if (int'(tap_idx) !== k)             begin bad++; $display("FAIL bp_resume_idx got=%0d want=%0d", tap_idx, k); end
            if (int'(tap_data) !== expect_tap(k)) begin bad++; $display("FAIL bp_resume_data k=%0d got=%0d want=%0d", k, tap_data, expect_tap(k)); end
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid_read();
        int kr;
        kr = (NTAP > 2) ? 2 : 1;
        do_reset();
        push(int'($urandom_range(1, 30000)));
        tap_ready = 1'b1;
        for (int k = 0; k < kr; k++) @(negedge clk);
        @(negedge clk);
        total++;
        if (int'(tap_idx) !== kr) begin bad++; $display("FAIL midrst_pre_idx got=%0d want=%0d", tap_idx, kr); end
        RST = 1'b0;
        #1;
        total += 6;
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        if (tap_valid !== 1'b0) begin bad++; $display("FAIL midrst_tap_valid got=%b want=0", tap_valid); end
        if (tap_data !== '0)    begin bad++; $display("FAIL midrst_tap_data got=%0d want=0", tap_data); end
        if (tap_idx !== '0)     begin bad++; $display("FAIL midrst_tap_idx got=%0d want=0", tap_idx); end
        if (tap_last !== 1'b0)  begin bad++; $display("FAIL midrst_tap_last got=%b want=0", tap_last); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        model_clear();
        @(negedge clk);
        RST = 1'b1;
        push(7);
        collect(1'b0);
        total++;
        if (ncol !== NTAP) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", ncol, NTAP); end
        for (int k = 0; k < ncol; k++) begin
            total++;
            if (cd[k] !== (k == 0 ? 7 : 0)) begin bad++; $display("FAIL midrst_seq k=%0d got=%0d want=%0d", k, cd[k], (k == 0 ? 7 : 0)); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(int'($urandom_range(0, 65535)) - 32768);
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL rand_read_flags n=%0d busy=%b in_ready=%b want busy=1 in_ready=0", n, busy, in_ready);
            end
            collect(1'b1);
            total++;
            if (ncol !== NTAP) begin bad++; $display("FAIL rand_count n=%0d got=%0d want=%0d", n, ncol, NTAP); end
            for (int k = 0; k < ncol; k++) begin
                total += 3;
                if (cd[k] !== expect_tap(k))     begin bad++; $display("FAIL rand_data n=%0d k=%0d got=%0d want=%0d", n, k, cd[k], expect_tap(k)); end
                if (ci[k] !== k)                 begin bad++; $display("FAIL rand_idx n=%0d got=%0d want=%0d", n, ci[k], k); end
                if (cl[k] !== int'(k == NTAP-1)) begin bad++; $display("FAIL rand_last n=%0d k=%0d got=%0d want=%0d", n, k, cl[k], int'(k == NTAP-1)); end
            end
        end
    endtask

`ifdef HILBERT_PAIR_EN
    task automatic test_pair();
        do_reset();
        for (int s = 1; s <= 4; s++) begin
            push(s);
            collect(1'b0);
        end
        total += 3;
        if (cd[0] !== 3) begin bad++; $display("FAIL pair_k0 got=%0d want=3", cd[0]); end
        if (cd[1] !== 1) begin bad++; $display("FAIL pair_k1 got=%0d want=1", cd[1]); end
        if (cl[1] !== 1 || cl[0] !== 0) begin bad++; $display("FAIL pair_last got=%0d%0d want=01", cl[0], cl[1]); end
        push(32767); collect(1'b0);
        push(0);     collect(1'b0);
        push(0);     collect(1'b0);
        push(-32768);
        collect(1'b0);
        total++;
        if (cd[0] !== -65535) begin bad++; $display("FAIL pair_extreme got=%0d want=-65535", cd[0]); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_single_push();
        test_wrap();
        test_backpressure();
        test_reset_mid_read();
        test_random();
`ifdef HILBERT_PAIR_EN
        test_pair();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilbert_tap_reader.md
# hilbert_tap_reader

Sample-side reader for the Hilbert filter delay line. It accepts one input sample per handshake and stores it in a circular buffer of `TAPS` registers. It then streams the current window, newest first, as a tap sequence over a valid/ready interface to the serial MAC stage. The block sits between the sample source and the coefficient MAC, replacing the free-running flip-flop chain with a buffer that the MAC reads in order.

## Interface
Parameters:
- `DATA_W`, 16: sample width, two's complement.
- `TAPS`, 8: delay-line depth, ≥2. Must be even when pair mode is compiled in.
- `IDX_W`, `$clog2(TAPS)`: tap index width (derived).
- `OUT_W`, `DATA_W` (`DATA_W+1` in pair mode): tap output width (derived).

Ports:
- `clk`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `in_data`  in  `DATA_W`  new sample.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  block can accept a sample.
- `tap_data`  out  `OUT_W`  current tap value.
- `tap_idx`  out  `IDX_W`  tap number k; k=0 is the newest sample.
- `tap_valid`  out  1  tap_data/tap_idx are valid.
- `tap_ready`  in  1  MAC accepts the tap.
- `tap_last`  out  1  final tap of the sequence.
- `busy`  out  1  high while in READ.

## Operation
- Two-state FSM.
  - IDLE: `in_ready`=1, `tap_valid`=0.
  - READ: `in_ready`=0, `tap_valid`=1.
- IDLE → READ: on `in_valid && in_ready`.
  - `in_data` is written to `buf[wp]`, then `wp` advances modulo `TAPS` (wraps from `TAPS-1` to 0).
  - k is set to 0.
- In READ, the tap output is `tap_data = buf[(wp_newest - k) mod TAPS]`, which equals x[n-k].
- A tap transfers when `tap_valid && tap_ready`. After a transfer, k increments.
- `tap_last` is asserted when k = `NTAP-1`.
  - `NTAP` = `TAPS` in normal mode, `TAPS/2` in pair mode.
- READ → IDLE: on the transfer of the last tap.
- `in_valid` is ignored while in READ. The source must hold its sample until `in_ready` is seen.
- Stall: while `tap_ready`=0, `tap_data`, `tap_idx` and `tap_last` hold stable.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=1, `tap_valid`=0, `tap_data`=0, `tap_idx`=0, `tap_last`=0, `busy`=0.
- Reset also clears every buffer entry to 0 and sets `wp`=0.
- Latency: the first tap is valid on the cycle after the accept edge.
- With `tap_ready` held high, each following tap appears one cycle after the previous one.
- `in_ready` rises on the cycle after the last transfer.
- Minimum sample period is `NTAP+1` cycles.
- `RST` asserted mid-READ: all state clears immediately (asynchronous) and the partially read sequence is dropped. Deassertion is synchronised externally.
- Before the buffer fills, unwritten taps read as 0.

## Configuration
- Macro: `HILBERT_PAIR_EN`.
- Defined (pair mode):
  - `NTAP` = `TAPS/2`.
  - `tap_data` = x[n-k] − x[n-(TAPS-1-k)], with both operands sign-extended to `DATA_W+1` bits, so the result never overflows.
  - This exploits the antisymmetric Hilbert coefficients.
- Undefined:
  - `NTAP` = `TAPS`.
  - `tap_data` = x[n-k], `DATA_W` bits wide.

## Structure
- Package `hilbert_pkg` holds:
  - `DATA_W` and `TAPS` defaults;
  - the `IDX_W` and `OUT_W` derivations;
  - the FSM state enum (`IDLE`, `READ`).
- One sub-module: `sample_ring`.
  - Contains the buffer and write pointer.
  - Has one write port and two combinational read ports indexed by k (the second port is used only in pair mode).
- FSM, k counter and output registers live in `hilbert_tap_reader`.

## Test plan
All scenarios use `TAPS`=4, `DATA_W`=16, normal mode unless stated.
- Reset: hold `RST`=0 → `in_ready`=1, `tap_valid`=0, `tap_data`=0, `busy`=0.
- Single push of 1 with `tap_ready`=1 → next four cycles give (k, data) = (0,1), (1,0), (2,0), (3,0); `tap_last` only at k=3; `in_ready`=1 on the following cycle.
- Push 1,2,3,4,5 → the sequence for 5 is 5,4,3,2, showing pointer wrap.
- Backpressure: `tap_ready`=0 for 3 cycles while k=1 → `tap_data`, `tap_idx`=1 and `tap_last`=0 stay stable; the sequence resumes at k=2.
- Reset mid-READ at k=2, then push 7 → outputs drop to reset values immediately; the next sequence is 7,0,0,0.
- `HILBERT_PAIR_EN`, push 1,2,3,4 → the sequence for 4 is (0, 3), (1, 1), with `tap_last` at k=1. Push −32768 after 32767,0,0 → k=0 gives −65535 in 17 bits.
